// File: rtl/gate_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : gate_test_sequencer
// Description : Walks a 2-input gate through all four input vectors and checks
//               each settled result against a truth table to reach a pass/fail verdict.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_test_sequencer #(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [3:0] TRUTH_TABLE   = 4'b0111
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       result,
    output logic       input1,
    output logic       input2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] failCount,
    output logic [1:0] failVector
);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_settle = 2'd1;
    localparam logic [1:0] c_check  = 2'd2;
    localparam logic [1:0] c_done   = 2'd3;

    localparam logic [7:0] c_settle_last = 8'(SETTLE_CYCLES - 1);

    logic [1:0] r_state;
    logic [1:0] r_vector;
    logic [7:0] r_cnt;
    logic [2:0] r_fail_count;
    logic [1:0] r_fail_vector;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;

    logic       w_mismatch;
    logic [2:0] w_fail_count_next;

    assign w_mismatch        = (result != TRUTH_TABLE[r_vector]);
    assign w_fail_count_next = w_mismatch ? (r_fail_count + 3'd1) : r_fail_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= c_idle;
            r_vector      <= 2'd0;
            r_cnt         <= 8'd0;
            r_fail_count  <= 3'd0;
            r_fail_vector <= 2'd0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (start) begin
                        r_vector      <= 2'd0;
                        r_cnt         <= 8'd0;
                        r_fail_count  <= 3'd0;
                        r_fail_vector <= 2'd0;
                        r_pass        <= 1'b0;
                        r_busy        <= 1'b1;
                        r_state       <= c_settle;
                    end
                end
                c_settle: begin
                    if (r_cnt == c_settle_last) begin
                        r_cnt   <= 8'd0;
                        r_state <= c_check;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                c_check: begin
                    if (w_mismatch && (r_fail_count == 3'd0)) begin
                        r_fail_vector <= r_vector;
                    end
                    r_fail_count <= w_fail_count_next;
                    if (r_vector == 2'd3) begin
                        // Verdict is registered here so it is already valid in the DONE cycle
                        r_pass  <= (w_fail_count_next == 3'd0);
                        r_done  <= 1'b1;
                        r_state <= c_done;
                    end else begin
                        r_vector <= r_vector + 2'd1;
                        r_state  <= c_settle;
                    end
                end
                c_done: begin
                    r_busy  <= 1'b0;
                    r_state <= c_idle;
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign input1     = r_vector[0];
    assign input2     = r_vector[1];
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign failCount  = r_fail_count;
    assign failVector = r_fail_vector;

endmodule
`default_nettype wire
